edge_detect_multi: RTL and testbench
====================================

// Module: edge_detect_multi
// PURPOSE
//  Multi-channel successor to the single-bit edge detector: per-channel input synchronizer,
//  debounce filter, registered rising/falling one-cycle pulses and optional sticky event flags.
//  Sits between raw board inputs (buttons, external strobes) and CPU/peripheral logic.
//  Every output is registered; all channels are independent and share one counter width.
// PARAMETERS
//  CHANNELS        4  number of independent input channels (>=1)
//  SYNC_STAGES     2  synchronizer flops per channel (>=2)
//  DEBOUNCE_CYCLES 8  consecutive stable cycles before a level change is accepted (0 and 1 are equivalent: no filtering)
// PORTS
//  clk          in   1         single clock; all logic on posedge
//  reset_n      in   1         synchronous reset, active low
//  in           in   CHANNELS  raw asynchronous inputs
//  level        out  CHANNELS  debounced, synchronized level
//  out_posedge  out  CHANNELS  1-cycle pulse on accepted 0->1 of level
//  out_negedge  out  CHANNELS  1-cycle pulse on accepted 1->0 of level
//  event_clear  in   CHANNELS  clears sticky flags of that channel (ignored when feature is off)
//  event_pos    out  CHANNELS  sticky rising-event flag (0 when feature is off)
//  event_neg    out  CHANNELS  sticky falling-event flag (0 when feature is off)
// BEHAVIOUR
//  - Reset (reset_n=0 at a clk edge): sync chain, level, counters, pulses and event flags all 0.
//  - Sync: in[i] shifts through SYNC_STAGES flops; s[i] = last stage.
//  - Debounce counter cnt[i], width $clog2(DEBOUNCE_CYCLES+1) (min 1):
//      s==level : cnt<=0
//      s!=level, cnt==DEBOUNCE_CYCLES-1 (or DEBOUNCE_CYCLES<=1): level<=s, cnt<=0
//      s!=level otherwise: cnt<=cnt+1
//    Any return of s to level before acceptance restarts the count (glitch rejected).
//  - Latency: a clean input step sampled at edge 1 shows on level after edge
//    SYNC_STAGES+max(DEBOUNCE_CYCLES,1).
//  - out_posedge[i] is 1 in exactly the cycle level[i] first reads 1; out_negedge[i] likewise
//    for 0. Never both in the same cycle; never two consecutive cycles on one channel.
//  - Input held high through reset release is treated as a 0->1 change: posedge fires after
//    normal latency.
//  - Simultaneous changes on several channels: each channel pulses in its own cycle, no
//    interaction.
//  - Reset mid-debounce: count discarded, level returns to 0, no pulse is generated by reset.
// CONFIGURATION
//  EDGE_DETECT_STICKY_EN defined:
//   event_pos[i] <= 1 on the edge out_posedge[i] is set; event_neg[i] likewise for negedge.
//   event_clear[i]=1 clears both flags of channel i at the next edge.
//   Set and clear in the same cycle: set wins (flag stays/becomes 1), the other flag clears.
//  EDGE_DETECT_STICKY_EN undefined:
//   event_pos/event_neg driven constant 0, event_clear unused; no flag registers; ports kept.
// TESTING (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless stated)
//  1 reset_n=0 with in=4'hF for 3 cycles -> all outputs 0; release -> level=4'hF after 6th edge,
//    out_posedge=4'hF for exactly that one cycle.
//  2 in[0] pulse high for 3 cycles then low -> level[0], out_posedge[0], out_negedge[0] stay 0.
//  3 in[1] 0->1 held 12 cycles then 1->0 -> out_posedge[1] one cycle 6 edges after rise,
//    out_negedge[1] one cycle 6 edges after fall.
//  4 in[0] and in[2] rise same cycle -> out_posedge=4'b0101 in one cycle; reset_n=0 at edge 4
//    of a second rise -> no pulse, level=0.
//  5 sticky build: posedge on ch3 -> event_pos[3]=1 held; event_clear[3] on same cycle as a new
//    posedge -> stays 1; event_clear[3] alone -> 0 next cycle; without macro event_* always 0.
//  6 DEBOUNCE_CYCLES=0 -> level follows a step after 3 edges; 1-cycle input glitch passes through.

Source files
------------

// File: rtl/edge_detect_multi.sv
// -----------------------------------------------------------------------------
// edge_detect_multi
//
// Multi-channel input conditioner for raw board signals (buttons, external
// strobes). Each channel has its own synchronizer chain, debounce filter,
// registered one-cycle rising/falling pulses and optional sticky event flags.
// Channels are fully independent; every output comes straight from a flop.
//
// Optional feature macro: EDGE_DETECT_STICKY_EN
//   defined   -> event_pos/event_neg are sticky flags, cleared by event_clear
//   undefined -> event_pos/event_neg tied to 0, event_clear is ignored
//
// Parameters
//   CHANNELS        number of independent channels (>=1)
//   SYNC_STAGES     synchronizer flops per channel (>=2)
//   DEBOUNCE_CYCLES stable cycles before a level change is accepted
//                   (0 and 1 both mean no filtering)
//
// Ports
//   clk          in   single clock, posedge
//   reset_n      in   synchronous reset, active low
//   in           in   raw asynchronous inputs, one bit per channel
//   level        out  debounced, synchronized level
//   out_posedge  out  one-cycle pulse when level goes 0->1
//   out_negedge  out  one-cycle pulse when level goes 1->0
//   event_clear  in   clears both sticky flags of a channel
//   event_pos    out  sticky rising-event flag
//   event_neg    out  sticky falling-event flag
// -----------------------------------------------------------------------------
module edge_detect_multi #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] out_posedge,
    output logic [CHANNELS-1:0] out_negedge,
    input  logic [CHANNELS-1:0] event_clear,
    output logic [CHANNELS-1:0] event_pos,
    output logic [CHANNELS-1:0] event_neg
);

    localparam int CW       = (DEBOUNCE_CYCLES <= 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_LAST = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_MAX = CW'(CNT_LAST);

    logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [CHANNELS-1:0]                  level_q, level_d;
    logic [CHANNELS-1:0]                  posedge_q, posedge_d;
    logic [CHANNELS-1:0]                  negedge_q, negedge_d;

    always_comb begin
        sync_d    = sync_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        posedge_d = '0;
        negedge_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], in[i]};
            cnt_d[i]  = '0;
            // Any sample that agrees with level restarts the count, so only an
            // uninterrupted run of differing samples gets accepted.
            if (sync_q[i][SYNC_STAGES-1] != level_q[i]) begin
                if ((DEBOUNCE_CYCLES <= 1) || (cnt_q[i] == CNT_MAX)) begin
                    level_d[i]   = sync_q[i][SYNC_STAGES-1];
                    posedge_d[i] = sync_q[i][SYNC_STAGES-1];
                    negedge_d[i] = ~sync_q[i][SYNC_STAGES-1];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= '0;
            posedge_q <= '0;
            negedge_q <= '0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            posedge_q <= posedge_d;
            negedge_q <= negedge_d;
        end
    end

    assign level       = level_q;
    assign out_posedge = posedge_q;
    assign out_negedge = negedge_q;

`ifdef EDGE_DETECT_STICKY_EN
    logic [CHANNELS-1:0] event_pos_q, event_pos_d;
    logic [CHANNELS-1:0] event_neg_q, event_neg_d;

    // A new edge beats a simultaneous clear; the opposite flag still clears.
    always_comb begin
        event_pos_d = (event_pos_q & ~event_clear) | posedge_d;
        event_neg_d = (event_neg_q & ~event_clear) | negedge_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            event_pos_q <= '0;
            event_neg_q <= '0;
        end else begin
            event_pos_q <= event_pos_d;
            event_neg_q <= event_neg_d;
        end
    end

    assign event_pos = event_pos_q;
    assign event_neg = event_neg_q;
`else
    logic unused_event_clear;
    assign unused_event_clear = ^event_clear;
    assign event_pos = '0;
    assign event_neg = '0;
`endif

endmodule

// File: tb/tb_edge_detect_multi.sv
module tb_edge_detect_multi;

    localparam int SYNC = 2;
    localparam int H    = 64;
`ifdef EDGE_DETECT_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] in_r;
    logic [3:0] event_clear;
    logic [3:0] lvl4, pos4, neg4, ep4, en4;
    logic [3:0] lvl0, pos0, neg0, ep0, en0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    edge_detect_multi #(.CHANNELS(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in(in_r), .level(lvl4),
        .out_posedge(pos4), .out_negedge(neg4), .event_clear(event_clear),
        .event_pos(ep4), .event_neg(en4)
    );

    edge_detect_multi #(.CHANNELS(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in(in_r), .level(lvl0),
        .out_posedge(pos0), .out_negedge(neg0), .event_clear(event_clear),
        .event_pos(ep0), .event_neg(en0)
    );

    // Reference model: per-edge history of sampled inputs and resets.
    // The synchronized value after edge k is the input sampled SYNC-1 edges
    // earlier unless a reset intervened. A level change is accepted once the
    // last D synchronized samples all disagree with the current level.
    logic [3:0] inh [H];
    logic       rh  [H];
    int         n = 0;
    logic [3:0] mlvl [2];
    logic [3:0] mpos [2];
    logic [3:0] mneg [2];
    logic [3:0] mep  [2];
    logic [3:0] men  [2];

    function automatic logic s_after(int k, int ch);
        if (k - SYNC + 1 < 1) return 1'b0;
        for (int j = k - SYNC + 1; j <= k; j++)
            if (rh[j % H]) return 1'b0;
        return inh[(k - SYNC + 1) % H][ch];
    endfunction

    always @(posedge clk) begin
        int         deff;
        logic [3:0] prev;
        logic       acc;
        n = n + 1;
        inh[n % H] = in_r;
        rh[n % H]  = !reset_n;
        for (int m = 0; m < 2; m++) begin
            deff = (m == 0) ? 4 : 1;
            prev = mlvl[m];
            if (!reset_n) begin
                mlvl[m] = 4'h0; mpos[m] = 4'h0; mneg[m] = 4'h0;
                mep[m]  = 4'h0; men[m]  = 4'h0;
            end else begin
                for (int ch = 0; ch < 4; ch++) begin
                    acc = 1'b1;
                    for (int k = n - deff; k <= n - 1; k++)
                        if (s_after(k, ch) == prev[ch]) acc = 1'b0;
                    mlvl[m][ch] = acc ? ~prev[ch] : prev[ch];
                end
                mpos[m] = mlvl[m] & ~prev;
                mneg[m] = ~mlvl[m] & prev;
                mep[m]  = mpos[m] | (mep[m] & ~event_clear);
                men[m]  = mneg[m] | (men[m] & ~event_clear);
            end
        end
    end

    task automatic clean_start();
        reset_n = 1'b0; in_r = 4'h0; event_clear = 4'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_r = 4'hF; event_clear = 4'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({lvl4, pos4, neg4, ep4, en4, lvl0, pos0, neg0, ep0, en0} !== 40'h0) begin
                errors++;
                $display("FAIL reset_outputs: got %h expected 0",
                         {lvl4, pos4, neg4, ep4, en4, lvl0, pos0, neg0, ep0, en0});
            end
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (lvl4 !== ((k >= 6) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL release_level edge %0d: got %h expected %h", k, lvl4, (k >= 6) ? 4'hF : 4'h0);
            end
            checks++;
            if (pos4 !== ((k == 6) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL release_posedge edge %0d: got %h expected %h", k, pos4, (k == 6) ? 4'hF : 4'h0);
            end
            checks++;
            if (pos0 !== ((k == 3) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL release_posedge_d0 edge %0d: got %h expected %h", k, pos0, (k == 3) ? 4'hF : 4'h0);
            end
        end
    endtask

    task automatic test_glitch();
        clean_start();
        in_r = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3) in_r = 4'b0000;
            checks++;
            if ({lvl4[0], pos4[0], neg4[0]} !== 3'b000) begin
                errors++;
                $display("FAIL glitch_reject edge %0d: got %b expected 000", k, {lvl4[0], pos4[0], neg4[0]});
            end
        end
    endtask

    task automatic test_rise_fall();
        clean_start();
        in_r = 4'b0010;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (pos4 !== ((k == 6) ? 4'b0010 : 4'b0000) || neg4 !== 4'h0) begin
                errors++;
                $display("FAIL rise_pulse edge %0d: got pos %b neg %b", k, pos4, neg4);
            end
        end
        in_r = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (neg4 !== ((k == 6) ? 4'b0010 : 4'b0000) || pos4 !== 4'h0
                || lvl4[1] !== (k < 6)) begin
                errors++;
                $display("FAIL fall_pulse edge %0d: got neg %b pos %b level %b", k, neg4, pos4, lvl4);
            end
        end
    endtask

    task automatic test_multi_and_reset();
        clean_start();
        in_r = 4'b0101;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (pos4 !== ((k == 6) ? 4'b0101 : 4'b0000)) begin
                errors++;
                $display("FAIL multi_posedge edge %0d: got %b expected %b", k, pos4, (k == 6) ? 4'b0101 : 4'b0000);
            end
        end
        in_r = 4'b0000;
        repeat (8) @(negedge clk);
        in_r = 4'b0101;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 3) begin reset_n = 1'b0; in_r = 4'b0000; end
            if (k == 4) reset_n = 1'b1;
            checks++;
            if (pos4 !== 4'h0 || lvl4 !== 4'h0) begin
                errors++;
                $display("FAIL reset_mid_debounce edge %0d: got pos %b level %b expected 0", k, pos4, lvl4);
            end
        end
    endtask

    task automatic test_sticky();
        clean_start();
        in_r = 4'b1000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (ep4[3] !== (STICKY && k >= 6) || pos4[3] !== (k == 6)) begin
                errors++;
                $display("FAIL sticky_set edge %0d: got ep %b pos %b", k, ep4[3], pos4[3]);
            end
        end
        in_r = 4'b0000;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (ep4[3] !== STICKY || en4[3] !== (STICKY && k >= 6)) begin
                errors++;
                $display("FAIL sticky_hold edge %0d: got ep %b en %b", k, ep4[3], en4[3]);
            end
        end
        in_r = 4'b1000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if (pos4[3] !== 1'b1 || ep4[3] !== STICKY || en4[3] !== 1'b0) begin
                    errors++;
                    $display("FAIL sticky_set_wins: got pos %b ep %b en %b expected 1 %b 0", pos4[3], ep4[3], en4[3], STICKY);
                end
            end
            if (k == 7) begin
                checks++;
                if (ep4[3] !== 1'b0 || en4[3] !== 1'b0) begin
                    errors++;
                    $display("FAIL sticky_clear: got ep %b en %b expected 0 0", ep4[3], en4[3]);
                end
            end
            event_clear = (k == 5 || k == 6) ? 4'b1000 : 4'b0000;
        end
    endtask

    task automatic test_no_debounce();
        clean_start();
        in_r = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (lvl0[0] !== (k >= 3) || pos0[0] !== (k == 3)) begin
                errors++;
                $display("FAIL d0_step edge %0d: got level %b pos %b", k, lvl0[0], pos0[0]);
            end
        end
        in_r = 4'b0011;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) in_r = 4'b0001;
            checks++;
            if (lvl0[1] !== (k == 3) || pos0[1] !== (k == 3) || neg0[1] !== (k == 4)
                || lvl4[1] !== 1'b0) begin
                errors++;
                $display("FAIL d0_glitch edge %0d: got level %b pos %b neg %b level_d4 %b",
                         k, lvl0[1], pos0[1], neg0[1], lvl4[1]);
            end
        end
    endtask

    task automatic test_random();
        clean_start();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checks++;
            if (lvl4 !== mlvl[0] || pos4 !== mpos[0] || neg4 !== mneg[0]
                || ep4 !== (STICKY ? mep[0] : 4'h0) || en4 !== (STICKY ? men[0] : 4'h0)) begin
                errors++;
                $display("FAIL random_d4 cycle %0d: got %h %h %h %h %h expected %h %h %h %h %h", c,
                         lvl4, pos4, neg4, ep4, en4, mlvl[0], mpos[0], mneg[0],
                         STICKY ? mep[0] : 4'h0, STICKY ? men[0] : 4'h0);
            end
            checks++;
            if (lvl0 !== mlvl[1] || pos0 !== mpos[1] || neg0 !== mneg[1]
                || ep0 !== (STICKY ? mep[1] : 4'h0) || en0 !== (STICKY ? men[1] : 4'h0)) begin
                errors++;
                $display("FAIL random_d0 cycle %0d: got %h %h %h %h %h expected %h %h %h %h %h", c,
                         lvl0, pos0, neg0, ep0, en0, mlvl[1], mpos[1], mneg[1],
                         STICKY ? mep[1] : 4'h0, STICKY ? men[1] : 4'h0);
            end
            checks++;
            if ((pos4 & neg4) !== 4'h0 || (pos0 & neg0) !== 4'h0) begin
                errors++;
                $display("FAIL random_both_pulses cycle %0d: got %b %b", c, pos4 & neg4, pos0 & neg0);
            end
            for (int ch = 0; ch < 4; ch++)
                if ($urandom_range(0, 5) == 0) in_r[ch] = ~in_r[ch];
            for (int ch = 0; ch < 4; ch++)
                event_clear[ch] = ($urandom_range(0, 7) == 0);
            reset_n = ($urandom_range(0, 99) != 0);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; in_r = 4'h0; event_clear = 4'h0;
        test_reset();
        test_glitch();
        test_rise_fall();
        test_multi_and_reset();
        test_sticky();
        test_no_debounce();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
